fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter STARTING_ADDR, default 'h01000000, meaning the byte address of memory word 0.
REQ-002 SHALL have parameter MEM_DEPTH_BYTES, default 'h0100000, meaning the size of the addressable memory window.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; the ports are clock and reset_n.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- clock, in, 1, rising-edge clock.
- reset_n, in, 1, async active-low reset.
- start, in, 1, begin fetching.
- mem_address, out, 32, byte address to main memory.
- mem_data_in, out, 32, write data to main memory; constant 0.
- mem_read_write, out, 1, constant READ (0).
- mem_data_out, in, 32, combinational read data from memory.
- redirect_valid, in, 1, load a new PC.
- redirect_pc, in, 32, redirect target.
- insn_valid, out, 1, instruction slot occupied.
- insn_ready, in, 1, consumer accepts the slot.
- insn, out, 32, fetched word.
- insn_pc, out, 32, address of insn.
- fault, out, 1, sticky address fault.

Function
REQ-005 SHALL implement an FSM with states IDLE, FETCH, STALL and FAULT.
REQ-006 SHALL drive mem_address = pc combinationally in every state.
REQ-007 SHALL, in IDLE, move to FETCH on the first posedge that samples start=1; no capture occurs in IDLE.
REQ-008 SHALL, in FETCH when (!insn_valid || insn_ready), capture at the posedge: insn<=mem_data_out, insn_pc<=pc, insn_valid<=1, pc<=pc+4.
- Latency: one cycle from pc presented to insn_valid.
- Throughput: one word per cycle while insn_ready=1.
REQ-009 SHALL, in FETCH when insn_valid && !insn_ready, go to STALL with pc, insn and insn_pc held.
REQ-010 SHALL, in STALL, hold all outputs until insn_ready=1; on that edge it SHALL capture the next word as in REQ-008 and return to FETCH.
REQ-011 SHALL give redirect_valid priority over capture in IDLE, FETCH and STALL:
- pc<=redirect_pc and insn_valid<=0 (pending word discarded).
- IDLE stays in IDLE; FETCH and STALL go to FETCH.
REQ-012 SHALL go to FAULT with fault<=1 on a redirect whose target has redirect_pc[1:0]!=0, is below STARTING_ADDR, or is at or above STARTING_ADDR+MEM_DEPTH_BYTES; in that case insn_valid<=0.
REQ-013 SHALL capture the last in-range word normally; if pc+4 is out of range (including 32-bit wrap), the same edge SHALL enter FAULT with fault<=1.
REQ-014 SHALL, in FAULT, perform no captures and keep pc frozen; a held insn_valid=1 SHALL clear after the next insn_ready=1, and redirects SHALL be ignored.
REQ-015 SHALL leave FAULT only via reset.
REQ-016 SHALL keep insn stable whenever insn_valid=1 and insn_ready=0.

Reset
REQ-017 SHALL, on reset_n=0 (asynchronous), set: state=IDLE, pc=STARTING_ADDR, insn_valid=0, insn=0, insn_pc=0, fault=0.
REQ-018 SHALL, while in reset, drive mem_address=STARTING_ADDR, mem_read_write=0 and mem_data_in=0.
REQ-019 SHALL, on reset asserted mid-stream, discard any pending word with no handshake; the first capture after release requires start again.

Configuration
REQ-020 SHALL, with FETCH_COUNT_EN defined, add output fetch_count[31:0]:
- Reset value 0.
- Increments on each cycle with insn_valid && insn_ready.
- Wraps at 2^32.
REQ-021 SHALL, without FETCH_COUNT_EN, omit the fetch_count port and its counter entirely.

Structure
REQ-022 SHALL place the following in package fetch_pkg: READ/WRITE constants, the state enum type, and the default STARTING_ADDR and MEM_DEPTH_BYTES.
REQ-023 SHALL contain one sub-module, fetch_pc_gen: next-PC mux (hold, +4, redirect) plus the range/alignment check, purely combinational.

Verification
REQ-024 SHALL cover: reset release, start pulse, insn_ready=1 with a preloaded image -> insn_pc 01000000, 01000004, 01000008 on consecutive cycles with matching words.
REQ-025 SHALL cover: insn_ready=0 for 3 cycles after the first capture -> insn and insn_pc held at 01000000, mem_address held at 01000004; then one word per cycle.
REQ-026 SHALL cover: redirect_pc=01000040 asserted while in STALL -> insn_valid=0 next cycle, then insn_pc=01000040.
REQ-027 SHALL cover: redirect_pc=01000042 -> fault=1, insn_valid=0; later redirects are ignored until reset.
REQ-028 SHALL cover: redirect to 010FFFFC -> that word is delivered, then fault=1 with no further captures.
REQ-029 SHALL cover, with FETCH_COUNT_EN: 10 accepted words, reset asserted mid-stream -> fetch_count=10 before reset and 0 after; outputs match REQ-017.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: memory direction
// constants, FSM state type, default memory window and a window check.
package fetch_pkg;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } mem_rw_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      STALL = 2'd2,
      FAULT = 2'd3
   } state_t;

   localparam logic [31:0] DEFAULT_STARTING_ADDR   = 32'h0100_0000;
   localparam logic [31:0] DEFAULT_MEM_DEPTH_BYTES = 32'h0010_0000;

   // Word-aligned and inside [base, base+depth); limit kept 33 bits wide
   // so a window touching the top of the address space cannot wrap.
   function automatic logic addr_ok(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] depth);
      logic [32:0] lim;
      lim = {1'b0, base} + {1'b0, depth};
      return (addr[1:0] == 2'b00) && (addr >= base) && ({1'b0, addr} < lim);
   endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selection and target range/alignment checking (combinational).
// Ports:
//   pc             current fetch address
//   redirect_valid redirect request (already gated off while faulted)
//   redirect_pc    redirect target
//   advance        a word is being captured this cycle
//   next_pc        value the PC register loads at the next edge
//   redirect_bad   redirect target misaligned or outside the memory window
//   seq_bad        pc+4 outside the window or wrapped past 2^32
module fetch_pc_gen
   import fetch_pkg::*;
#(
   parameter logic [31:0] STARTING_ADDR   = DEFAULT_STARTING_ADDR,
   parameter logic [31:0] MEM_DEPTH_BYTES = DEFAULT_MEM_DEPTH_BYTES
) (
   input  logic [31:0] pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        advance,
   output logic [31:0] next_pc,
   output logic        redirect_bad,
   output logic        seq_bad
);

   logic [32:0] seq_sum;

   assign seq_sum      = {1'b0, pc} + 33'd4;
   assign redirect_bad = !addr_ok(redirect_pc, STARTING_ADDR, MEM_DEPTH_BYTES);
   assign seq_bad      = seq_sum[32] ||
                         !addr_ok(seq_sum[31:0], STARTING_ADDR, MEM_DEPTH_BYTES);

   // Redirect wins; an illegal target or illegal increment freezes the PC.
   always_comb begin
      next_pc = pc;
      if (redirect_valid) begin
         if (!redirect_bad) next_pc = redirect_pc;
      end else if (advance && !seq_bad) begin
         next_pc = seq_sum[31:0];
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: streams words from a combinational-read memory
// into a single-entry valid/ready slot, with redirects and a sticky fault.
// Ports:
//   clock, reset_n        rising-edge clock, async active-low reset
//   start                 leave IDLE and begin fetching
//   mem_address           byte address to memory (always the current PC)
//   mem_data_in           write data, tied to 0
//   mem_read_write        tied to READ
//   mem_data_out          combinational read data
//   redirect_valid/_pc    load a new PC, discarding any pending word
//   insn_valid/ready      output slot handshake
//   insn, insn_pc         fetched word and its address
//   fault                 sticky address fault, cleared only by reset
//   fetch_count           accepted-word counter (only with FETCH_COUNT_EN)
// Optional feature macro: FETCH_COUNT_EN
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] STARTING_ADDR   = DEFAULT_STARTING_ADDR,
   parameter logic [31:0] MEM_DEPTH_BYTES = DEFAULT_MEM_DEPTH_BYTES
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   output logic        mem_read_write,
   input  logic [31:0] mem_data_out,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        insn_valid,
   input  logic        insn_ready,
   output logic [31:0] insn,
   output logic [31:0] insn_pc,
`ifdef FETCH_COUNT_EN
   output logic [31:0] fetch_count,
`endif
   output logic        fault
);

   state_t      state;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic        redirect_bad;
   logic        seq_bad;
   logic        redirect_live;
   logic        capture;

   assign mem_address    = pc;
   assign mem_data_in    = 32'h0;
   assign mem_read_write = READ;

   // Redirects are dead once faulted; capture only when the slot frees up.
   assign redirect_live = redirect_valid && (state != FAULT);
   assign capture       = ((state == FETCH) || (state == STALL)) &&
                          (!insn_valid || insn_ready) && !redirect_valid;

   fetch_pc_gen #(
      .STARTING_ADDR   (STARTING_ADDR),
      .MEM_DEPTH_BYTES (MEM_DEPTH_BYTES)
   ) u_pc_gen (
      .pc             (pc),
      .redirect_valid (redirect_live),
      .redirect_pc    (redirect_pc),
      .advance        (capture),
      .next_pc        (next_pc),
      .redirect_bad   (redirect_bad),
      .seq_bad        (seq_bad)
   );

   // Control FSM and output slot.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         pc         <= STARTING_ADDR;
         insn_valid <= 1'b0;
         insn       <= 32'h0;
         insn_pc    <= 32'h0;
         fault      <= 1'b0;
      end else begin
         pc <= next_pc;
         case (state)
            IDLE, FETCH, STALL: begin
               if (redirect_valid) begin
                  insn_valid <= 1'b0;
                  if (redirect_bad) begin
                     state <= FAULT;
                     fault <= 1'b1;
                  end else if (state != IDLE) begin
                     state <= FETCH;
                  end
               end else if (capture) begin
                  insn       <= mem_data_out;
                  insn_pc    <= pc;
                  insn_valid <= 1'b1;
                  // Last in-window word is still delivered before faulting.
                  if (seq_bad) begin
                     state <= FAULT;
                     fault <= 1'b1;
                  end else begin
                     state <= FETCH;
                  end
               end else if (state == IDLE) begin
                  if (start) state <= FETCH;
               end else begin
                  state <= STALL;
               end
            end
            FAULT: begin
               if (insn_ready) insn_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FETCH_COUNT_EN
   // Accepted-word counter, wraps naturally at 2^32.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fetch_count <= 32'h0;
      end else if (insn_valid && insn_ready) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the stimulus pushes expected insn_pc
// values, a negedge monitor pops and checks every accepted word.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic [31:0] mem_address;
   logic [31:0] mem_data_in;
   logic        mem_read_write;
   logic [31:0] mem_data_out;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        insn_valid;
   logic        insn_ready = 1'b0;
   logic [31:0] insn;
   logic [31:0] insn_pc;
   logic        fault;
`ifdef FETCH_COUNT_EN
   logic [31:0] fetch_count;
`endif

   int checks = 0;
   int failures = 0;
   logic [31:0] sb[$];

   always #5 clock = ~clock;

   // Memory image: each word is its address half-swapped and xor-ed.
   function automatic logic [31:0] img(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
   endfunction

   assign mem_data_out = img(mem_address);

   fetch_unit dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .start          (start),
      .mem_address    (mem_address),
      .mem_data_in    (mem_data_in),
      .mem_read_write (mem_read_write),
      .mem_data_out   (mem_data_out),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .insn_valid     (insn_valid),
      .insn_ready     (insn_ready),
      .insn           (insn),
      .insn_pc        (insn_pc),
`ifdef FETCH_COUNT_EN
      .fetch_count    (fetch_count),
`endif
      .fault          (fault)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Monitor: every accepted word must be the next scoreboard entry.
   always @(negedge clock) begin
      if (reset_n && insn_valid === 1'b1 && insn_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected: got pc %h with empty scoreboard", insn_pc);
         end else begin
            logic [31:0] e;
            e = sb.pop_front();
            chk("sb_pc", insn_pc, e);
            chk("sb_insn", insn, img(e));
         end
      end
   end

   task automatic do_reset;
      tick;
      reset_n = 1'b0;
      start = 1'b0;
      redirect_valid = 1'b0;
      insn_ready = 1'b0;
      #1;
      chk("sb_drained", 32'(sb.size()), 32'd0);
      chk("rst_mem_address", mem_address, 32'h0100_0000);
      chk("rst_mem_rw", 32'(mem_read_write), 32'd0);
      chk("rst_mem_data_in", mem_data_in, 32'h0);
      chk("rst_insn_valid", 32'(insn_valid), 32'd0);
      chk("rst_insn", insn, 32'h0);
      chk("rst_insn_pc", insn_pc, 32'h0);
      chk("rst_fault", 32'(fault), 32'd0);
`ifdef FETCH_COUNT_EN
      chk("rst_fetch_count", fetch_count, 32'h0);
`endif
      tick;
      tick;
      reset_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Streaming with insn_ready=1.
      do_reset();
      tick;
      chk("idle_no_capture", 32'(insn_valid), 32'd0);
      insn_ready = 1'b1;
      start = 1'b1;
      sb.push_back(32'h0100_0000);
      sb.push_back(32'h0100_0004);
      tick;
      start = 1'b0;
      chk("t1_not_yet", 32'(insn_valid), 32'd0);
      tick;
      chk("t1_valid", 32'(insn_valid), 32'd1);
      chk("t1_pc0", insn_pc, 32'h0100_0000);
      chk("t1_insn0", insn, img(32'h0100_0000));
      tick;
      chk("t1_pc1", insn_pc, 32'h0100_0004);
      tick;
      chk("t1_pc2", insn_pc, 32'h0100_0008);
      chk("t1_insn2", insn, img(32'h0100_0008));
      insn_ready = 1'b0;

      // Backpressure for three edges after the first capture.
      do_reset();
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      chk("t2_pc0", insn_pc, 32'h0100_0000);
      chk("t2_addr0", mem_address, 32'h0100_0004);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("t2_hold_valid", 32'(insn_valid), 32'd1);
         chk("t2_hold_pc", insn_pc, 32'h0100_0000);
         chk("t2_hold_insn", insn, img(32'h0100_0000));
         chk("t2_hold_addr", mem_address, 32'h0100_0004);
      end
      insn_ready = 1'b1;
      sb.push_back(32'h0100_0000);
      sb.push_back(32'h0100_0004);
      sb.push_back(32'h0100_0008);
      tick;
      chk("t2_pc1", insn_pc, 32'h0100_0004);
      tick;
      chk("t2_pc2", insn_pc, 32'h0100_0008);
      tick;
      chk("t2_pc3", insn_pc, 32'h0100_000C);
      insn_ready = 1'b0;

      // Redirect while stalled.
      tick;
      chk("t3_stalled_pc", insn_pc, 32'h0100_000C);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0100_0040;
      tick;
      redirect_valid = 1'b0;
      chk("t3_flushed", 32'(insn_valid), 32'd0);
      chk("t3_addr", mem_address, 32'h0100_0040);
      insn_ready = 1'b1;
      sb.push_back(32'h0100_0040);
      tick;
      chk("t3_pc40", insn_pc, 32'h0100_0040);
      chk("t3_valid", 32'(insn_valid), 32'd1);
      tick;
      chk("t3_pc44", insn_pc, 32'h0100_0044);
      insn_ready = 1'b0;

      // Misaligned redirect faults; later redirects ignored.
      do_reset();
      insn_ready = 1'b1;
      start = 1'b1;
      sb.push_back(32'h0100_0000);
      tick;
      start = 1'b0;
      tick;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0100_0042;
      tick;
      chk("t4_fault", 32'(fault), 32'd1);
      chk("t4_valid", 32'(insn_valid), 32'd0);
      chk("t4_addr", mem_address, 32'h0100_0004);
      redirect_pc = 32'h0100_0040;
      tick;
      redirect_valid = 1'b0;
      chk("t4_fault_sticky", 32'(fault), 32'd1);
      chk("t4_ignored_addr", mem_address, 32'h0100_0004);
      tick;
      chk("t4_no_capture", 32'(insn_valid), 32'd0);

      // Below-window redirect from IDLE.
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc = 32'h00FF_FFFC;
      tick;
      redirect_valid = 1'b0;
      chk("t5_low_fault", 32'(fault), 32'd1);
      chk("t5_low_addr", mem_address, 32'h0100_0000);

      // Last word of the window is delivered, then fault.
      do_reset();
      insn_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h010F_FFFC;
      tick;
      redirect_valid = 1'b0;
      chk("t6_idle_addr", mem_address, 32'h010F_FFFC);
      chk("t6_idle_fault", 32'(fault), 32'd0);
      tick;
      chk("t6_idle_novalid", 32'(insn_valid), 32'd0);
      start = 1'b1;
      sb.push_back(32'h010F_FFFC);
      tick;
      start = 1'b0;
      tick;
      chk("t6_last_valid", 32'(insn_valid), 32'd1);
      chk("t6_last_pc", insn_pc, 32'h010F_FFFC);
      chk("t6_last_fault", 32'(fault), 32'd1);
      tick;
      chk("t6_cleared", 32'(insn_valid), 32'd0);
      tick;
      chk("t6_no_more", 32'(insn_valid), 32'd0);
      chk("t6_fault_held", 32'(fault), 32'd1);

`ifdef FETCH_COUNT_EN
      // Ten accepted words, then reset mid-stream.
      do_reset();
      insn_ready = 1'b1;
      start = 1'b1;
      for (int i = 0; i < 10; i++) sb.push_back(32'h0100_0000 + 32'(4 * i));
      tick;
      start = 1'b0;
      repeat (11) tick;
      insn_ready = 1'b0;
      chk("t7_count10", fetch_count, 32'd10);
`endif

      do_reset();
      chk("sb_final_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
